// File: rtl/sprite_attr_engine.sv
// ============================================================================
// sprite_attr_engine : vblank sprite-attribute fetch into a shadow table with
// atomic swap, plus a registered per-pixel priority hit test.  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sprite_attr_engine #(
  parameter int          NUM_SPRITES = 8,
  parameter int          SPRITE_SIZE = 16,
  parameter int          ADDR_W      = 16,
  parameter int unsigned ATTR_BASE   = 16'h4FF0,
  parameter int unsigned XY_BASE     = 16'h5060,
  parameter int          RD_LATENCY  = 1,
  parameter int          ROW_W       = 9,
  parameter int          COL_W       = 10,
  localparam int         IDX_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  localparam int         PIX_W       = $clog2(SPRITE_SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vblank,
  input  logic [ROW_W-1:0]  row,
  input  logic [COL_W-1:0]  col,
  input  logic [7:0]        sprite_RAM_din,
  output logic              rd_en,
  output logic [ADDR_W-1:0] sprite_RAM_addr,
  output logic              load_done,
  output logic              load_abort,
  output logic              hit,
  output logic [IDX_W-1:0]  hit_idx,
  output logic [5:0]        sprite_code,
  output logic [7:0]        palette,
  output logic [PIX_W-1:0]  pix_x,
  output logic [PIX_W-1:0]  pix_y
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Table entry layout: [7:0] code/flip, [15:8] palette, [23:16] X, [31:24] Y
  state_t             state_q, state_d;
  logic               vblank_d_q;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         byte_q, byte_d;
  logic [1:0]         wait_q, wait_d;
  logic [31:0]        shadow_q [NUM_SPRITES];
  logic [31:0]        shadow_d [NUM_SPRITES];
  logic [31:0]        active_q [NUM_SPRITES];
  logic [31:0]        active_d [NUM_SPRITES];

  logic               hit_q, hit_d;
  logic [IDX_W-1:0]   hit_idx_q, hit_idx_d;
  logic [5:0]         code_q, code_d;
  logic [7:0]         pal_q, pal_d;
  logic [PIX_W-1:0]   pix_x_q, pix_x_d;
  logic [PIX_W-1:0]   pix_y_q, pix_y_d;

  logic               rd_en_w, load_done_w, load_abort_w;
  logic [ADDR_W-1:0]  addr_w;
  logic [COL_W:0]     dx;
  logic [ROW_W:0]     dy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      vblank_d_q <= 1'b0;
      idx_q      <= '0;
      byte_q     <= '0;
      wait_q     <= '0;
      hit_q      <= 1'b0;
      hit_idx_q  <= '0;
      code_q     <= '0;
      pal_q      <= '0;
      pix_x_q    <= '0;
      pix_y_q    <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      vblank_d_q <= vblank;
      idx_q      <= idx_d;
      byte_q     <= byte_d;
      wait_q     <= wait_d;
      hit_q      <= hit_d;
      hit_idx_q  <= hit_idx_d;
      code_q     <= code_d;
      pal_q      <= pal_d;
      pix_x_q    <= pix_x_d;
      pix_y_q    <= pix_y_d;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    byte_d       = byte_q;
    wait_d       = wait_q;
    rd_en_w      = 1'b0;
    load_done_w  = 1'b0;
    load_abort_w = 1'b0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = active_q[i];
    end

    // Losing vblank mid-fetch drops the partial load; DONE always completes.
    if (!vblank && (state_q == S_ISSUE || state_q == S_WAIT || state_q == S_CAPTURE)) begin
      state_d      = S_IDLE;
      load_abort_w = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (vblank && !vblank_d_q) begin
            state_d = S_ISSUE;
            idx_d   = '0;
            byte_d  = '0;
          end
        end
        S_ISSUE: begin
          rd_en_w = 1'b1;
          wait_d  = '0;
          state_d = (RD_LATENCY == 1) ? S_CAPTURE : S_WAIT;
        end
        S_WAIT: begin
          if (int'(wait_q) + 2 >= RD_LATENCY) state_d = S_CAPTURE;
          else                                 wait_d  = wait_q + 2'd1;
        end
        S_CAPTURE: begin
          shadow_d[idx_q][{byte_q, 3'b000} +: 8] = sprite_RAM_din;
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3 && idx_q == IDX_W'(NUM_SPRITES - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            if (byte_q == 2'd3) idx_d = idx_q + 1'b1;
          end
        end
        S_DONE: begin
          load_done_w = 1'b1;
          state_d     = S_IDLE;
          for (int i = 0; i < NUM_SPRITES; i++) active_d[i] = shadow_q[i];
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    addr_w = (byte_q[1] ? ADDR_W'(XY_BASE) : ADDR_W'(ATTR_BASE))
           + ADDR_W'({idx_q, 1'b0}) + ADDR_W'(byte_q[0]);
  end

  // Scan high to low so the lowest covering index is the last writer.
  always_comb begin
    hit_d     = 1'b0;
    hit_idx_d = '0;
    code_d    = '0;
    pal_d     = '0;
    pix_x_d   = '0;
    pix_y_d   = '0;
    dx        = '0;
    dy        = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      dx = {1'b0, col} - {{(COL_W - 7){1'b0}}, active_q[i][23:16]};
      dy = {1'b0, row} - {{(ROW_W - 7){1'b0}}, active_q[i][31:24]};
      if (!dx[COL_W] && !dy[ROW_W] &&
          dx < (COL_W + 1)'(SPRITE_SIZE) && dy < (ROW_W + 1)'(SPRITE_SIZE)) begin
        hit_d     = 1'b1;
        hit_idx_d = IDX_W'(i);
        code_d    = active_q[i][7:2];
        pal_d     = active_q[i][15:8];
        pix_x_d   = active_q[i][0] ? ~dx[PIX_W-1:0] : dx[PIX_W-1:0];
        pix_y_d   = active_q[i][1] ? ~dy[PIX_W-1:0] : dy[PIX_W-1:0];
      end
    end
  end

  assign rd_en           = rd_en_w;
  assign sprite_RAM_addr = rd_en_w ? addr_w : '0;
  assign load_done       = load_done_w;
  assign load_abort      = load_abort_w;
  assign hit             = hit_q;
  assign hit_idx         = hit_idx_q;
  assign sprite_code     = code_q;
  assign palette         = pal_q;
  assign pix_x           = pix_x_q;
  assign pix_y           = pix_y_q;

endmodule

`default_nettype wire

// File: tb/tb_sprite_attr_engine.sv
// ============================================================================
// tb_sprite_attr_engine : directed bench for sprite_attr_engine with one DUT
// at read latency 1 and one at read latency 3 sharing video inputs. Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sprite_attr_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vblank;
  logic [8:0]  row;
  logic [9:0]  col;

  logic [7:0]  din_l1, din_l3, p3_0, p3_1;
  logic        rd_en_l1, rd_en_l3;
  logic [15:0] addr_l1, addr_l3;
  logic        done_l1, done_l3, abort_l1, abort_l3;
  logic        hit_l1, hit_l3;
  logic [2:0]  idx_l1, idx_l3;
  logic [5:0]  code_l1, code_l3;
  logic [7:0]  pal_l1, pal_l3;
  logic [3:0]  px_l1, px_l3, py_l1, py_l3;

  logic [7:0]  mem [0:65535];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sprite_attr_engine #(.RD_LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .vblank(vblank), .row(row), .col(col),
    .sprite_RAM_din(din_l1), .rd_en(rd_en_l1), .sprite_RAM_addr(addr_l1),
    .load_done(done_l1), .load_abort(abort_l1), .hit(hit_l1), .hit_idx(idx_l1),
    .sprite_code(code_l1), .palette(pal_l1), .pix_x(px_l1), .pix_y(py_l1)
  );

  sprite_attr_engine #(.RD_LATENCY(3)) u_dut_l3 (
    .clk(clk), .rst_n(rst_n), .vblank(vblank), .row(row), .col(col),
    .sprite_RAM_din(din_l3), .rd_en(rd_en_l3), .sprite_RAM_addr(addr_l3),
    .load_done(done_l3), .load_abort(abort_l3), .hit(hit_l3), .hit_idx(idx_l3),
    .sprite_code(code_l3), .palette(pal_l3), .pix_x(px_l3), .pix_y(py_l3)
  );

  // Sprite RAM models with 1- and 3-cycle read pipelines
  always @(posedge clk) begin
    din_l1 <= mem[addr_l1];
    p3_0   <= mem[addr_l3];
    p3_1   <= p3_0;
    din_l3 <= p3_1;
  end

  int cyc = 0;
  int rd_cnt_l1 = 0, rd_cnt_l3 = 0, last_rd_l1 = 0, last_rd_l3 = 0;
  int gap_bad_l1 = 0, gap_bad_l3 = 0;
  int ld_cnt_l1 = 0, ld_cnt_l3 = 0, ab_cnt_l1 = 0, ab_cnt_l3 = 0;
  logic [15:0] first_addr_l1 = '0, last_addr_l1 = '0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rd_en_l1) begin
      if (rd_cnt_l1 > 0 && cyc - last_rd_l1 != 2) gap_bad_l1 = gap_bad_l1 + 1;
      if (rd_cnt_l1 == 0) first_addr_l1 = addr_l1;
      last_addr_l1 = addr_l1;
      last_rd_l1   = cyc;
      rd_cnt_l1    = rd_cnt_l1 + 1;
    end
    if (rd_en_l3) begin
      if (rd_cnt_l3 > 0 && cyc - last_rd_l3 != 4) gap_bad_l3 = gap_bad_l3 + 1;
      last_rd_l3 = cyc;
      rd_cnt_l3  = rd_cnt_l3 + 1;
    end
    if (done_l1)  ld_cnt_l1 = ld_cnt_l1 + 1;
    if (done_l3)  ld_cnt_l3 = ld_cnt_l3 + 1;
    if (abort_l1) ab_cnt_l1 = ab_cnt_l1 + 1;
    if (abort_l3) ab_cnt_l3 = ab_cnt_l3 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_counts();
    rd_cnt_l1 = 0; rd_cnt_l3 = 0; gap_bad_l1 = 0; gap_bad_l3 = 0;
    ld_cnt_l1 = 0; ld_cnt_l3 = 0; ab_cnt_l1 = 0; ab_cnt_l3 = 0;
  endtask

  task automatic probe(input logic [8:0] r, input logic [9:0] c);
    @(posedge clk); #1;
    row = r; col = c;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int done_at_l1, done_at_l3, base;

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = a[7:0];
    rst_n = 1'b0; vblank = 1'b0; row = 9'd300; col = 10'd500;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en",  {31'd0, rd_en_l1}, 32'd0);
    check("rst_addr",   {16'd0, addr_l1},  32'd0);
    check("rst_hit",    {31'd0, hit_l1},   32'd0);
    check("rst_done",   {31'd0, done_l1},  32'd0);
    check("rst_abort",  {31'd0, abort_l3}, 32'd0);

    rst_n = 1'b1;
    clear_counts();
    repeat (20) @(posedge clk);
    #1;
    check("idle_no_reads", rd_cnt_l1 + rd_cnt_l3, 32'd0);

    // Frame 1: two overlapping sprites on row 30
    mem[16'h4FF0] = 8'h04; mem[16'h4FF2] = 8'h08;
    mem[16'h5060] = 8'd20; mem[16'h5061] = 8'd30;
    mem[16'h5062] = 8'd25; mem[16'h5063] = 8'd30;
    clear_counts();
    done_at_l1 = 0; done_at_l3 = 0;
    @(posedge clk); #1;
    vblank = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (done_l1 && done_at_l1 == 0) done_at_l1 = n;
      if (done_l3 && done_at_l3 == 0) done_at_l3 = n;
    end
    vblank = 1'b0;
    check("l1_done_latency", done_at_l1, 32'd65);
    check("l3_done_latency", done_at_l3, 32'd129);
    check("l1_done_once",    ld_cnt_l1,  32'd1);
    check("l3_done_once",    ld_cnt_l3,  32'd1);
    check("l1_rd_count",     rd_cnt_l1,  32'd32);
    check("l3_rd_count",     rd_cnt_l3,  32'd32);
    check("l1_rd_spacing",   gap_bad_l1, 32'd0);
    check("l3_rd_spacing",   gap_bad_l3, 32'd0);
    check("l1_first_addr",   {16'd0, first_addr_l1}, 32'h4FF0);
    check("l1_last_addr",    {16'd0, last_addr_l1},  32'h506F);

    probe(9'd30, 10'd26);
    check("pri_hit",   {31'd0, hit_l1}, 32'd1);
    check("pri_idx",   {29'd0, idx_l1}, 32'd0);
    check("pri_pix_x", {28'd0, px_l1},  32'd6);
    check("pri_pix_y", {28'd0, py_l1},  32'd0);
    check("pri_code",  {26'd0, code_l1}, 32'd1);
    probe(9'd30, 10'd36);
    check("s1_idx",    {29'd0, idx_l1}, 32'd1);
    check("s1_pix_x",  {28'd0, px_l1},  32'd11);
    check("s1_code",   {26'd0, code_l1}, 32'd2);
    probe(9'd30, 10'd41);
    check("miss_hit",  {31'd0, hit_l1}, 32'd0);
    check("miss_code", {26'd0, code_l1}, 32'd0);
    check("miss_pal",  {24'd0, pal_l1},  32'd0);
    probe(9'd30, 10'd19);
    check("left_edge_miss", {31'd0, hit_l1}, 32'd0);
    probe(9'd45, 10'd20);
    check("corner_hit",   {31'd0, hit_l1}, 32'd1);
    check("corner_pix_x", {28'd0, px_l1},  32'd0);
    check("corner_pix_y", {28'd0, py_l1},  32'd15);
    probe(9'd101, 10'd100);
    check("l3_s2_idx",   {29'd0, idx_l3},  32'd2);
    check("l3_s2_pix_x", {28'd0, px_l3},   32'd0);
    check("l3_s2_code",  {26'd0, code_l3}, 32'h3D);
    check("l3_s2_pal",   {24'd0, pal_l3},  32'hF5);
    probe(9'd101, 10'd115);
    check("l3_s2_right", {28'd0, px_l3},   32'd15);

    // Abort after 10 bytes on the latency-1 engine
    mem[16'h5060] = 8'd200;
    clear_counts();
    base = 0;
    @(posedge clk); #1;
    vblank = 1'b1;
    for (int n = 0; n < 100 && rd_cnt_l1 < 10; n++) begin
      @(posedge clk); #1;
    end
    vblank = 1'b0;
    #1;
    check("abort_pulse", {31'd0, abort_l1}, 32'd1);
    check("abort_rd_en", {31'd0, rd_en_l1}, 32'd0);
    @(posedge clk); #1;
    check("abort_one_cycle", {31'd0, abort_l1}, 32'd0);
    repeat (100) @(posedge clk);
    #1;
    check("abort_rd_stop",  rd_cnt_l1, 32'd10);
    check("abort_no_done",  ld_cnt_l1 + ld_cnt_l3, 32'd0);
    check("abort_cnt_l1",   ab_cnt_l1, 32'd1);
    check("abort_cnt_l3",   ab_cnt_l3, 32'd1);
    probe(9'd30, 10'd26);
    check("abort_keep_hit",  {31'd0, hit_l1}, 32'd1);
    check("abort_keep_idx",  {29'd0, idx_l1}, 32'd0);
    check("abort_keep_pix",  {28'd0, px_l1},  32'd6);
    check("abort_keep_l3",   {28'd0, px_l3},  32'd6);

    // Flipped sprite at origin
    mem[16'h4FF0] = 8'h07; mem[16'h5060] = 8'd0; mem[16'h5061] = 8'd0;
    clear_counts();
    @(posedge clk); #1;
    vblank = 1'b1;
    for (int n = 0; n < 300 && ld_cnt_l3 == 0; n++) begin
      @(posedge clk); #1;
    end
    vblank = 1'b0;
    check("flip_done_l1", ld_cnt_l1, 32'd1);
    probe(9'd2, 10'd3);
    check("flip_hit",   {31'd0, hit_l1},  32'd1);
    check("flip_code",  {26'd0, code_l1}, 32'd1);
    check("flip_pix_x", {28'd0, px_l1},   32'd12);
    check("flip_pix_y", {28'd0, py_l1},   32'd13);
    check("flip_pal",   {24'd0, pal_l1},  32'hF1);

    // Reset in the middle of a load
    @(posedge clk); #1;
    vblank = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rd_en", {30'd0, rd_en_l1, rd_en_l3}, 32'd0);
    check("mid_rst_hit",   {30'd0, hit_l1, hit_l3},     32'd0);
    check("mid_rst_done",  {31'd0, done_l1},            32'd0);
    vblank = 1'b0;
    @(posedge clk); #1;
    clear_counts();
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_no_reads", rd_cnt_l1 + rd_cnt_l3, 32'd0);
    probe(9'd5, 10'd5);
    check("cleared_hit",   {31'd0, hit_l1},  32'd1);
    check("cleared_pix_x", {28'd0, px_l1},   32'd5);
    check("cleared_pix_y", {28'd0, py_l1},   32'd5);
    check("cleared_code",  {26'd0, code_l1}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sprite_attr_engine.md
Name: sprite_attr_engine

Overview:
Parametrised sprite attribute fetch and hit-test engine; successor to the fixed 8-sprite sprite datapath FSM.
- During vblank, walks NUM_SPRITES entries in sprite RAM and loads code/flip, palette, X and Y into a shadow table, with configurable RAM read latency.
- Swaps the shadow table into the active table atomically on a complete load.
- During active video, resolves per (row, col) the highest-priority covering sprite and emits its code, palette and in-sprite pixel offsets to the sprite tile/colour stage.

Parameters:
NUM_SPRITES, 8, number of sprite entries fetched per frame (1..64)
SPRITE_SIZE, 16, sprite edge in pixels (power of 2)
ADDR_W, 16, sprite RAM address width
ATTR_BASE, 16'h4FF0, base of code/flip + palette byte pairs
XY_BASE, 16'h5060, base of X + Y byte pairs
RD_LATENCY, 1, cycles from rd_en to valid sprite_RAM_din (1..4)
ROW_W, 9, row counter width
COL_W, 10, column counter width

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
vblank  input  1  vertical blank from VGA timing
row  input  ROW_W  current display row
col  input  COL_W  current display column
sprite_RAM_din  input  8  read data, valid RD_LATENCY cycles after rd_en
rd_en  output  1  read strobe, one cycle per byte
sprite_RAM_addr  output  ADDR_W  read address
load_done  output  1  one-cycle pulse on table swap
load_abort  output  1  one-cycle pulse when vblank falls mid-load
hit  output  1  some sprite covers (row, col)
hit_idx  output  $clog2(NUM_SPRITES)  index of winning sprite
sprite_code  output  6  winning sprite code
palette  output  8  winning sprite palette byte
pix_x  output  $clog2(SPRITE_SIZE)  flip-corrected column within sprite
pix_y  output  $clog2(SPRITE_SIZE)  flip-corrected row within sprite

Behaviour:
- Reset: all outputs 0; FSM in IDLE; shadow and active tables all-zero (X=Y=0, code 0, palette 0).
- Load start: rising edge of vblank (registered vblank_d) while in IDLE.
- Byte order per sprite i, with k = 0..3:
  - k0: ATTR_BASE+2i, code byte (code = [7:2], xflip = [0], yflip = [1])
  - k1: ATTR_BASE+2i+1, palette
  - k2: XY_BASE+2i, X
  - k3: XY_BASE+2i+1, Y
  - Addresses are computed modulo 2^ADDR_W.
- FSM states: IDLE -> ISSUE -> WAIT -> CAPTURE -> (ISSUE for next byte | DONE) -> IDLE.
  - ISSUE: rd_en=1 for exactly one cycle, address valid in the same cycle.
  - WAIT: lasts RD_LATENCY-1 cycles; zero cycles when RD_LATENCY=1.
  - CAPTURE: latches sprite_RAM_din into the shadow slot.
  - Per byte: RD_LATENCY+1 cycles. Full load: 4*NUM_SPRITES*(RD_LATENCY+1) cycles plus 1 cycle for DONE.
- DONE: copies shadow to active in one cycle and pulses load_done.
- Abort: vblank=0 in any non-IDLE state other than DONE:
  - returns to IDLE next cycle, pulses load_abort
  - active table unchanged; shadow content don't-care
  - rd_en deasserted the same cycle
- No restart until the next vblank rising edge. vblank held high after DONE does not retrigger.
- Hit test: combinational on the active table, registered once, so outputs lag row/col by 1 cycle.
  - dx = {1'b0,col} - X, width COL_W+1; dy = {1'b0,row} - Y, width ROW_W+1.
  - Sprite covers when both dx and dy are non-negative and < SPRITE_SIZE (no wrap).
  - Priority: lowest index wins.
  - pix_x = xflip ? SPRITE_SIZE-1-dx : dx; pix_y uses yflip likewise.
  - No cover: hit=0 and all other hit-test outputs 0.
- Hit test runs continuously, including during vblank. The table swap takes effect on the cycle after DONE.
- Reset mid-load: immediate return to reset state; tables cleared.

Test Plan:
- Reset: rst_n=0 mid-load -> rd_en=0, hit=0, load_done=0, FSM IDLE; release, no vblank -> no reads.
- Full load, RD_LATENCY=1, NUM_SPRITES=8, RAM model returning addr[7:0]:
  - 32 rd_en pulses, 2 cycles apart; first address 16'h4FF0, last 16'h506F
  - load_done pulses once 65 cycles after vblank rise
- Latency sweep, RD_LATENCY=3: rd_en spacing 4 cycles; captured X for sprite 2 equals the byte at 16'h5064.
- Hit/priority, sprite0 X=20 Y=30 and sprite1 X=25 Y=30:
  - row=30, col=26 -> next cycle hit=1, hit_idx=0, pix_x=6, pix_y=0
  - col=36 -> hit_idx=1, pix_x=11
  - col=41 -> hit=0
- Flip: sprite0 code byte 8'h07 (code 1, xflip=1, yflip=1), X=Y=0:
  - row=2, col=3 -> sprite_code=1, pix_x=12, pix_y=13
- Abort: vblank drops after 10 bytes -> load_abort pulse, rd_en stops, no load_done, hit-test results match the previous frame's table.
